// File: rtl/l2_dir_if.sv
// rtl/l2_dir_if.sv - l2_dir L1.5-facing message bundle plus shared message/MESI encodings
// Stats outputs exist only when DIR_STATS_EN is defined.
`ifndef L2_DIR_DEFS_SVH
`define L2_DIR_DEFS_SVH
`define MSG_WIDTH  4
`define TAG_WIDTH  8
`define DATA_WIDTH 8
`define MESI_WIDTH 2
`define MSG_TYPE_EMPTY        4'd0
`define MSG_TYPE_LOAD_REQ     4'd1
`define MSG_TYPE_STORE_REQ    4'd2
`define MSG_TYPE_DATA_ACK     4'd3
`define MSG_TYPE_WB_REQ       4'd4
`define MSG_TYPE_INV_FWD      4'd5
`define MSG_TYPE_LOAD_FWD     4'd6
`define MSG_TYPE_STORE_FWD    4'd7
`define MSG_TYPE_INV_FWDACK   4'd8
`define MSG_TYPE_LOAD_FWDACK  4'd9
`define MSG_TYPE_STORE_FWDACK 4'd10
`define MESI_I 2'd0
`define MESI_S 2'd1
`define MESI_E 2'd2
`define MESI_M 2'd3
`endif

interface l2_dir_if;
  logic [`MSG_WIDTH-1:0]  msg1_type_0, msg1_type_1, msg3_type_0, msg3_type_1;
  logic [`TAG_WIDTH-1:0]  msg1_tag_0, msg1_tag_1, msg3_tag_0, msg3_tag_1;
  logic [`DATA_WIDTH-1:0] msg1_data_0, msg1_data_1, msg3_data_0, msg3_data_1;
  logic [`MSG_WIDTH-1:0]  msg2_type_0, msg2_type_1;
  logic [`DATA_WIDTH-1:0] msg2_data_0, msg2_data_1;
  logic [`TAG_WIDTH-1:0]  msg2_tag_0, msg2_tag_1;
  logic [`MESI_WIDTH-1:0] mesi_send_0, mesi_send_1;
  logic                   proto_err;
`ifdef DIR_STATS_EN
  logic [15:0]            req_cnt, fwd_cnt;
`endif

  modport master (
    output msg1_type_0, msg1_type_1, msg1_tag_0, msg1_tag_1, msg1_data_0, msg1_data_1,
    output msg3_type_0, msg3_type_1, msg3_tag_0, msg3_tag_1, msg3_data_0, msg3_data_1,
    input  msg2_type_0, msg2_type_1, msg2_data_0, msg2_data_1, msg2_tag_0, msg2_tag_1,
    input  mesi_send_0, mesi_send_1,
`ifdef DIR_STATS_EN
    input  req_cnt, fwd_cnt,
`endif
    input  proto_err
  );

  modport slave (
    input  msg1_type_0, msg1_type_1, msg1_tag_0, msg1_tag_1, msg1_data_0, msg1_data_1,
    input  msg3_type_0, msg3_type_1, msg3_tag_0, msg3_tag_1, msg3_data_0, msg3_data_1,
    output msg2_type_0, msg2_type_1, msg2_data_0, msg2_data_1, msg2_tag_0, msg2_tag_1,
    output mesi_send_0, mesi_send_1,
`ifdef DIR_STATS_EN
    output req_cnt, fwd_cnt,
`endif
    output proto_err
  );
endinterface

// File: rtl/l2_dir.sv
// rtl/l2_dir.sv - shared L2/directory for two single-line L1.5 caches with shadow MESI tags
// Optional DIR_STATS_EN adds saturating req_cnt/fwd_cnt outputs.
module l2_dir #(
  parameter int MEM_AW = 4,
  parameter int NCORE  = 2
) (
  input logic   clk,
  input logic   rst,
  l2_dir_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WAIT_ACK, S_GRANT, S_RESP} state_t;
  localparam int DEPTH = 1 << MEM_AW;

  logic [`MSG_WIDTH-1:0]  msg1_type [2], msg3_type [2];
  logic [`TAG_WIDTH-1:0]  msg1_tag [2];
  logic [`DATA_WIDTH-1:0] msg3_data [2];
  assign msg1_type[0] = bus.msg1_type_0;  assign msg1_type[1] = bus.msg1_type_1;
  assign msg3_type[0] = bus.msg3_type_0;  assign msg3_type[1] = bus.msg3_type_1;
  assign msg1_tag[0]  = bus.msg1_tag_0;   assign msg1_tag[1]  = bus.msg1_tag_1;
  assign msg3_data[0] = bus.msg3_data_0;  assign msg3_data[1] = bus.msg3_data_1;

  logic unused_ok;
  assign unused_ok = ^{bus.msg1_data_0, bus.msg1_data_1, bus.msg3_tag_0, bus.msg3_tag_1, 32'(NCORE)};

  state_t                 state_q, state_d;
  logic                   req_q, req_d, last_q, last_d, store_q, store_d, first_q, first_d;
  logic [`TAG_WIDTH-1:0]  tag_q, tag_d;
  logic [`MSG_WIDTH-1:0]  ack_type_q, ack_type_d;
  logic [`MESI_WIDTH-1:0] peer_nxt_q, peer_nxt_d;
  logic [`MESI_WIDTH-1:0] shadow_q [2], shadow_d [2];
  logic [`TAG_WIDTH-1:0]  shadow_tag_q [2], shadow_tag_d [2];
  logic [1:0]             wb_cons_q, wb_cons_d, ack_cons_q, ack_cons_d;
  logic [`DATA_WIDTH-1:0] mem_q [DEPTH], mem_d [DEPTH];
  logic [`MSG_WIDTH-1:0]  msg2_type_q [2], msg2_type_d [2];
  logic [`DATA_WIDTH-1:0] msg2_data_q [2], msg2_data_d [2];
  logic [`TAG_WIDTH-1:0]  msg2_tag_q [2], msg2_tag_d [2];
  logic [`MESI_WIDTH-1:0] mesi_q [2], mesi_d [2];
  logic                   proto_err_q, proto_err_d;
  logic                   pend0, pend1, sel, o, fwd_sent, ack_sent;
  logic [`MSG_WIDTH-1:0]  fwd;
  logic [`MESI_WIDTH-1:0] nxt;

  always_comb begin
    state_d = state_q;  req_d = req_q;  last_d = last_q;  store_d = store_q;
    first_d = first_q;  tag_d = tag_q;  ack_type_d = ack_type_q;  peer_nxt_d = peer_nxt_q;
    shadow_d = shadow_q;  shadow_tag_d = shadow_tag_q;  mem_d = mem_q;
    wb_cons_d = wb_cons_q;  ack_cons_d = ack_cons_q;  proto_err_d = proto_err_q;
    for (int i = 0; i < 2; i++) begin
      msg2_type_d[i] = `MSG_TYPE_EMPTY;
      msg2_data_d[i] = '0;
      msg2_tag_d[i]  = '0;
      mesi_d[i]      = `MESI_I;
    end
    pend0 = (msg1_type[0] == `MSG_TYPE_LOAD_REQ) || (msg1_type[0] == `MSG_TYPE_STORE_REQ);
    pend1 = (msg1_type[1] == `MSG_TYPE_LOAD_REQ) || (msg1_type[1] == `MSG_TYPE_STORE_REQ);
    sel = (pend0 && pend1) ? ~last_q : pend1;
    o = ~req_q;
    fwd = `MSG_TYPE_EMPTY;
    nxt = shadow_q[o];
    fwd_sent = 1'b0;
    ack_sent = 1'b0;
    case (state_q)
      S_IDLE: if (pend0 || pend1) begin
        req_d   = sel;
        tag_d   = msg1_tag[sel];
        store_d = (msg1_type[sel] == `MSG_TYPE_STORE_REQ);
        state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        // A dirty line being replaced must arrive as WB_REQ alongside the new request.
        if (shadow_q[req_q] == `MESI_M && shadow_tag_q[req_q] != tag_q) begin
          if (msg3_type[req_q] != `MSG_TYPE_WB_REQ) proto_err_d = 1'b1;
          else if (!wb_cons_q[req_q]) begin
            mem_d[shadow_tag_q[req_q][MEM_AW-1:0]] = msg3_data[req_q];
            wb_cons_d[req_q] = 1'b1;
          end
        end
        if (shadow_tag_q[o] == tag_q && shadow_q[o] != `MESI_I) begin
          if (shadow_q[o] == `MESI_M) begin
            fwd = `MSG_TYPE_STORE_FWD;  nxt = `MESI_I;
          end else if (store_q) begin
            fwd = `MSG_TYPE_INV_FWD;  nxt = `MESI_I;
          end else if (shadow_q[o] == `MESI_E) begin
            fwd = `MSG_TYPE_LOAD_FWD;  nxt = `MESI_S;
          end
        end
        if (fwd != `MSG_TYPE_EMPTY) begin
          msg2_type_d[o] = fwd;
          msg2_tag_d[o]  = tag_q;
          ack_cons_d[o]  = 1'b0;
          ack_type_d     = fwd + 4'd3;
          peer_nxt_d     = nxt;
          first_d        = 1'b1;
          fwd_sent       = 1'b1;
          state_d        = S_WAIT_ACK;
        end else begin
          state_d = S_GRANT;
        end
      end
      S_WAIT_ACK: begin
        // msg3 of the peer is stale during the cycle the forward is visible.
        if (first_q) first_d = 1'b0;
        else if (msg3_type[o] == ack_type_q && !ack_cons_q[o]) begin
          ack_cons_d[o] = 1'b1;
          shadow_d[o]   = peer_nxt_q;
          if (ack_type_q == `MSG_TYPE_STORE_FWDACK) mem_d[tag_q[MEM_AW-1:0]] = msg3_data[o];
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        msg2_type_d[req_q] = `MSG_TYPE_DATA_ACK;
        msg2_data_d[req_q] = mem_q[tag_q[MEM_AW-1:0]];
        msg2_tag_d[req_q]  = tag_q;
        if (store_q) mesi_d[req_q] = `MESI_M;
        else if (shadow_q[o] == `MESI_S && shadow_tag_q[o] == tag_q) mesi_d[req_q] = `MESI_S;
        else mesi_d[req_q] = `MESI_E;
        state_d = S_RESP;
      end
      S_RESP: begin
        shadow_d[req_q]     = mesi_q[req_q];
        shadow_tag_d[req_q] = tag_q;
        wb_cons_d[req_q]    = 1'b0;
        ack_cons_d[req_q]   = 1'b0;
        last_d              = req_q;
        ack_sent            = 1'b1;
        state_d             = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;  req_q <= 1'b0;  last_q <= 1'b0;  store_q <= 1'b0;  first_q <= 1'b0;
      tag_q <= '0;  ack_type_q <= '0;  peer_nxt_q <= `MESI_I;
      wb_cons_q <= '0;  ack_cons_q <= '0;  proto_err_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        shadow_q[i] <= `MESI_I;  shadow_tag_q[i] <= '0;
        msg2_type_q[i] <= `MSG_TYPE_EMPTY;  msg2_data_q[i] <= '0;
        msg2_tag_q[i] <= '0;  mesi_q[i] <= `MESI_I;
      end
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;  req_q <= req_d;  last_q <= last_d;  store_q <= store_d;  first_q <= first_d;
      tag_q <= tag_d;  ack_type_q <= ack_type_d;  peer_nxt_q <= peer_nxt_d;
      wb_cons_q <= wb_cons_d;  ack_cons_q <= ack_cons_d;  proto_err_q <= proto_err_d;
      shadow_q <= shadow_d;  shadow_tag_q <= shadow_tag_d;  mem_q <= mem_d;
      msg2_type_q <= msg2_type_d;  msg2_data_q <= msg2_data_d;
      msg2_tag_q <= msg2_tag_d;  mesi_q <= mesi_d;
    end
  end

  assign bus.msg2_type_0 = msg2_type_q[0];  assign bus.msg2_type_1 = msg2_type_q[1];
  assign bus.msg2_data_0 = msg2_data_q[0];  assign bus.msg2_data_1 = msg2_data_q[1];
  assign bus.msg2_tag_0  = msg2_tag_q[0];   assign bus.msg2_tag_1  = msg2_tag_q[1];
  assign bus.mesi_send_0 = mesi_q[0];       assign bus.mesi_send_1 = mesi_q[1];
  assign bus.proto_err   = proto_err_q;

`ifdef DIR_STATS_EN
  logic [15:0] req_cnt_q, req_cnt_d, fwd_cnt_q, fwd_cnt_d;
  always_comb begin
    req_cnt_d = req_cnt_q;
    fwd_cnt_d = fwd_cnt_q;
    if (ack_sent && req_cnt_q != 16'hFFFF) req_cnt_d = req_cnt_q + 16'd1;
    if (fwd_sent && fwd_cnt_q != 16'hFFFF) fwd_cnt_d = fwd_cnt_q + 16'd1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_cnt_q <= '0;
      fwd_cnt_q <= '0;
    end else begin
      req_cnt_q <= req_cnt_d;
      fwd_cnt_q <= fwd_cnt_d;
    end
  end
  assign bus.req_cnt = req_cnt_q;
  assign bus.fwd_cnt = fwd_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = fwd_sent ^ ack_sent;
`endif
endmodule

// File: tb/tb_l2_dir.sv
// tb/tb_l2_dir.sv - scoreboard bench for l2_dir: grants, forwards, writebacks, round-robin, reset
`ifndef L2_DIR_DEFS_SVH
`define L2_DIR_DEFS_SVH
`define MSG_WIDTH  4
`define TAG_WIDTH  8
`define DATA_WIDTH 8
`define MESI_WIDTH 2
`define MSG_TYPE_EMPTY        4'd0
`define MSG_TYPE_LOAD_REQ     4'd1
`define MSG_TYPE_STORE_REQ    4'd2
`define MSG_TYPE_DATA_ACK     4'd3
`define MSG_TYPE_WB_REQ       4'd4
`define MSG_TYPE_INV_FWD      4'd5
`define MSG_TYPE_LOAD_FWD     4'd6
`define MSG_TYPE_STORE_FWD    4'd7
`define MSG_TYPE_INV_FWDACK   4'd8
`define MSG_TYPE_LOAD_FWDACK  4'd9
`define MSG_TYPE_STORE_FWDACK 4'd10
`define MESI_I 2'd0
`define MESI_S 2'd1
`define MESI_E 2'd2
`define MESI_M 2'd3
`endif

module tb_l2_dir;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  l2_dir_if bus();
  l2_dir #(.MEM_AW(4), .NCORE(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic       c;
    logic [7:0] tag;
    logic [7:0] data;
    logic [1:0] mesi;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int checks = 0;
  int errors = 0;
  int acks_seen = 0;
  int fwds_sent = 0;
  int n;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic set_msg1(input int c, input logic [3:0] t, input logic [7:0] tg);
    if (c == 0) begin bus.msg1_type_0 = t; bus.msg1_tag_0 = tg; end
    else        begin bus.msg1_type_1 = t; bus.msg1_tag_1 = tg; end
  endtask

  task automatic set_msg3(input int c, input logic [3:0] t, input logic [7:0] d);
    if (c == 0) begin bus.msg3_type_0 = t; bus.msg3_data_0 = d; end
    else        begin bus.msg3_type_1 = t; bus.msg3_data_1 = d; end
  endtask

  function automatic logic [3:0] m2_type(input int c);
    return (c == 0) ? bus.msg2_type_0 : bus.msg2_type_1;
  endfunction

  function automatic logic [7:0] m2_tag(input int c);
    return (c == 0) ? bus.msg2_tag_0 : bus.msg2_tag_1;
  endfunction

  // Scoreboard side: every DATA_ACK pops one expected grant.
  always @(negedge clk) begin
    if (!rst) begin
      for (int c = 0; c < 2; c++) begin
        if (m2_type(c) == `MSG_TYPE_DATA_ACK) begin
          acks_seen++;
          if (sb_q.size() == 0) check_eq("unexpected_ack_core", c, 32'hFF);
          else begin
            e = sb_q.pop_front();
            check_eq("ack_core", c, e.c);
            check_eq("ack_data", (c == 0) ? bus.msg2_data_0 : bus.msg2_data_1, e.data);
            check_eq("ack_tag", m2_tag(c), e.tag);
            check_eq("ack_mesi", (c == 0) ? bus.mesi_send_0 : bus.mesi_send_1, e.mesi);
            check_eq("ack_other_empty", m2_type(1 - c), `MSG_TYPE_EMPTY);
          end
        end
      end
    end
  end

  task automatic run_req(input int c, input bit st, input logic [7:0] tag, input bit wb,
                         input logic [7:0] wbd, input logic [3:0] exp_fwd, input logic [7:0] ackd,
                         input logic [7:0] exp_data, input logic [1:0] exp_mesi);
    int o = 1 - c;
    @(negedge clk);
    sb_q.push_back('{c[0], tag, exp_data, exp_mesi});
    set_msg1(c, st ? `MSG_TYPE_STORE_REQ : `MSG_TYPE_LOAD_REQ, tag);
    if (wb) set_msg3(c, `MSG_TYPE_WB_REQ, wbd);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("fwd_type", m2_type(o), exp_fwd);
    if (exp_fwd != `MSG_TYPE_EMPTY) begin
      fwds_sent++;
      check_eq("fwd_tag", m2_tag(o), tag);
      set_msg3(o, exp_fwd + 4'd3, ackd);
      repeat (3) @(posedge clk);
    end else begin
      @(posedge clk);
    end
    @(negedge clk);
    check_eq("ack_latency", m2_type(c), `MSG_TYPE_DATA_ACK);
    set_msg1(c, `MSG_TYPE_EMPTY, 8'h00);
    set_msg3(0, `MSG_TYPE_EMPTY, 8'h00);
    set_msg3(1, `MSG_TYPE_EMPTY, 8'h00);
    @(posedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus.msg1_data_0 = '0;  bus.msg1_data_1 = '0;  bus.msg3_tag_0 = '0;  bus.msg3_tag_1 = '0;
    set_msg1(0, `MSG_TYPE_EMPTY, 8'h00);  set_msg1(1, `MSG_TYPE_EMPTY, 8'h00);
    set_msg3(0, `MSG_TYPE_EMPTY, 8'h00);  set_msg3(1, `MSG_TYPE_EMPTY, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_msg2_0", bus.msg2_type_0, `MSG_TYPE_EMPTY);
    check_eq("rst_msg2_1", bus.msg2_type_1, `MSG_TYPE_EMPTY);
    check_eq("rst_mesi_0", bus.mesi_send_0, `MESI_I);
    check_eq("rst_proto_err", bus.proto_err, 1'b0);
    rst = 1'b0;

    // Both cores request together: core1 first (rr starts at core0), core0 four cycles later.
    @(negedge clk);
    sb_q.push_back('{1'b1, 8'h31, 8'h00, `MESI_E});
    sb_q.push_back('{1'b0, 8'h20, 8'h00, `MESI_E});
    set_msg1(0, `MSG_TYPE_LOAD_REQ, 8'h20);
    set_msg1(1, `MSG_TYPE_LOAD_REQ, 8'h31);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rr_first", m2_type(1), `MSG_TYPE_DATA_ACK);
    set_msg1(1, `MSG_TYPE_EMPTY, 8'h00);
    for (n = 0; n < 20 && m2_type(0) != `MSG_TYPE_DATA_ACK; n++) @(negedge clk);
    check_eq("rr_second_latency", n, 4);
    set_msg1(0, `MSG_TYPE_EMPTY, 8'h00);
    @(posedge clk);

    //       core st tag    wb  wbdata fwd                    ackd   data   mesi
    run_req(0, 1, 8'h03, 0, 8'h00, `MSG_TYPE_EMPTY,     8'h00, 8'h00, `MESI_M);
    run_req(0, 0, 8'h05, 1, 8'hA5, `MSG_TYPE_EMPTY,     8'h00, 8'h00, `MESI_E);
    run_req(1, 0, 8'h03, 0, 8'h00, `MSG_TYPE_EMPTY,     8'h00, 8'hA5, `MESI_E);
    run_req(0, 1, 8'h03, 0, 8'h00, `MSG_TYPE_INV_FWD,   8'h00, 8'hA5, `MESI_M);
    run_req(1, 1, 8'h03, 0, 8'h00, `MSG_TYPE_STORE_FWD, 8'h5A, 8'h5A, `MESI_M);
    run_req(0, 0, 8'h02, 0, 8'h00, `MSG_TYPE_EMPTY,     8'h00, 8'h00, `MESI_E);
    run_req(1, 0, 8'h02, 1, 8'h77, `MSG_TYPE_LOAD_FWD,  8'h00, 8'h00, `MESI_S);
    run_req(0, 0, 8'h02, 0, 8'h00, `MSG_TYPE_EMPTY,     8'h00, 8'h00, `MESI_S);
    run_req(0, 1, 8'h02, 0, 8'h00, `MSG_TYPE_INV_FWD,   8'h00, 8'h00, `MESI_M);
    run_req(1, 0, 8'h03, 0, 8'h00, `MSG_TYPE_EMPTY,     8'h00, 8'h77, `MESI_E);
    check_eq("proto_err_clean", bus.proto_err, 1'b0);
    run_req(0, 0, 8'h04, 0, 8'h00, `MSG_TYPE_EMPTY,     8'h00, 8'h00, `MESI_E);
    check_eq("proto_err_set", bus.proto_err, 1'b1);
`ifdef DIR_STATS_EN
    check_eq("req_cnt", bus.req_cnt, acks_seen);
    check_eq("fwd_cnt", bus.fwd_cnt, fwds_sent);
`endif

    // Reset while waiting for the forward ack.
    @(negedge clk);
    set_msg1(1, `MSG_TYPE_STORE_REQ, 8'h04);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_test_fwd", m2_type(0), `MSG_TYPE_INV_FWD);
    rst = 1'b1;
    #1;
    check_eq("arst_msg2_0", bus.msg2_type_0, `MSG_TYPE_EMPTY);
    check_eq("arst_tag_0", bus.msg2_tag_0, 8'h00);
    check_eq("arst_msg2_1", bus.msg2_type_1, `MSG_TYPE_EMPTY);
    check_eq("arst_proto_err", bus.proto_err, 1'b0);
    set_msg1(1, `MSG_TYPE_EMPTY, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    run_req(0, 0, 8'h03, 0, 8'h00, `MSG_TYPE_EMPTY,     8'h00, 8'h00, `MESI_E);

    repeat (4) @(posedge clk);
    check_eq("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
